// File: rtl/fifo_ram_ctrl.sv
// fifo_ram_ctrl: single-clock first-word-fall-through FIFO controller for the
// fifo_ram macro (1-cycle registered read address, combinational read data).
// Owns write/read pointers, occupancy flags and the prefetched head entry.
// Optional feature macro: FIFO_CTRL_ALMOST_EN adds a registered almost_full output.
module fifo_ram_ctrl #(
    parameter int WIDTH           = 32,
    parameter int FIFO_DEPTH      = 4,
    parameter int A_WIDTH         = $clog2(FIFO_DEPTH),
    parameter int ALMOST_FULL_LVL = FIFO_DEPTH - 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               push_valid,
    output logic               push_ready,
    input  logic [WIDTH-1:0]   push_data,
    output logic               pop_valid,
    input  logic               pop_ready,
    output logic [WIDTH-1:0]   pop_data,
    output logic [A_WIDTH:0]   count,
    output logic               full,
    output logic               empty,
    output logic [A_WIDTH-1:0] ram_waddr,
    output logic               ram_wen,
    output logic [WIDTH-1:0]   ram_wdata,
    output logic [A_WIDTH-1:0] ram_raddr,
    output logic               ram_ren,
    input  logic [WIDTH-1:0]   ram_rdata
`ifdef FIFO_CTRL_ALMOST_EN
    ,
    output logic               almost_full
`endif
);

    localparam logic [A_WIDTH:0] DEPTH_C = (A_WIDTH + 1)'(FIFO_DEPTH);
    localparam logic [A_WIDTH:0] PTR_ONE = {{A_WIDTH{1'b0}}, 1'b1};

    // Pointers carry one extra MSB so full and empty are distinguishable.
    logic [A_WIDTH:0] r_wr_ptr;
    logic [A_WIDTH:0] r_rd_ptr;
    logic             r_head_valid;

    logic [A_WIDTH:0] w_wr_ptr_nxt;
    logic [A_WIDTH:0] w_rd_ptr_nxt;
    logic             w_head_valid_nxt;

    logic [A_WIDTH:0] w_fetchable;
    logic [A_WIDTH:0] w_count;
    logic             w_full;
    logic             w_push_fire;
    logic             w_pop_fire;
    logic             w_wen;
    logic             w_ren;

    // Entries written but not yet fetched; the head slot is counted separately
    // and stays reserved in the RAM until it is popped.
    assign w_fetchable = r_wr_ptr - r_rd_ptr;
    assign w_count     = w_fetchable + {{A_WIDTH{1'b0}}, r_head_valid};
    assign w_full      = (w_count == DEPTH_C);

    // push_ready depends only on occupancy, never on pop_ready.
    assign push_ready  = !rst && !w_full;
    assign w_push_fire = push_valid && push_ready;
    assign w_pop_fire  = r_head_valid && pop_ready;

    // A flush cycle still advertises push_ready but writes nothing.
    assign w_wen = w_push_fire && !flush;

    // Fetch the next entry whenever the head slot is free or being vacated,
    // which keeps back-to-back pops at one per cycle.
    assign w_ren = (w_fetchable != '0) && (!r_head_valid || w_pop_fire) && !flush && !rst;

    assign ram_wen   = w_wen;
    assign ram_waddr = r_wr_ptr[A_WIDTH-1:0];
    assign ram_wdata = push_data;
    assign ram_ren   = w_ren;
    assign ram_raddr = r_rd_ptr[A_WIDTH-1:0];

    assign pop_valid = r_head_valid;
    assign pop_data  = ram_rdata;
    assign count     = w_count;
    assign full      = w_full;
    assign empty     = (w_count == '0);

    // Next-state of pointers and head flag; flush clears everything.
    always_comb begin
        w_wr_ptr_nxt     = r_wr_ptr;
        w_rd_ptr_nxt     = r_rd_ptr;
        w_head_valid_nxt = r_head_valid;
        if (flush) begin
            w_wr_ptr_nxt     = '0;
            w_rd_ptr_nxt     = '0;
            w_head_valid_nxt = 1'b0;
        end else begin
            if (w_wen) begin
                w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
            end
            if (w_ren) begin
                w_rd_ptr_nxt     = r_rd_ptr + PTR_ONE;
                w_head_valid_nxt = 1'b1;
            end else if (w_pop_fire) begin
                w_head_valid_nxt = 1'b0;
            end
        end
    end

    // Pointer and head-flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_head_valid <= 1'b0;
        end else begin
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_head_valid <= w_head_valid_nxt;
        end
    end

`ifdef FIFO_CTRL_ALMOST_EN
    localparam logic [A_WIDTH:0] AF_LVL_C = (A_WIDTH + 1)'(ALMOST_FULL_LVL);

    logic [A_WIDTH:0] w_count_nxt;
    logic             r_almost_full;

    assign w_count_nxt = (w_wr_ptr_nxt - w_rd_ptr_nxt) + {{A_WIDTH{1'b0}}, w_head_valid_nxt};

    // almost_full is registered from the occupancy the next edge will produce.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_almost_full <= 1'b0;
        end else begin
            r_almost_full <= (w_count_nxt >= AF_LVL_C);
        end
    end

    assign almost_full = r_almost_full;
`else
    logic w_unused_almost_lvl;
    assign w_unused_almost_lvl = (ALMOST_FULL_LVL != 0);
`endif

endmodule
